// File: rtl/booth_mac_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiply-accumulate unit.
package booth_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Booth triplets {b[2k+1], b[2k], b[2k-1]}
    localparam logic [2:0] TRIP_ZERO_L = 3'b000;
    localparam logic [2:0] TRIP_P1_L   = 3'b001;
    localparam logic [2:0] TRIP_P1_H   = 3'b010;
    localparam logic [2:0] TRIP_P2     = 3'b011;
    localparam logic [2:0] TRIP_M2     = 3'b100;
    localparam logic [2:0] TRIP_M1_L   = 3'b101;
    localparam logic [2:0] TRIP_M1_H   = 3'b110;
    localparam logic [2:0] TRIP_ZERO_H = 3'b111;

    // Number of CALC cycles needed to retire all N/2+1 Booth digits.
    function automatic int calc_cycles(input int n_bits, input int gpc);
        int g;
        g = n_bits / 2 + 1;
        return (g + gpc - 1) / gpc;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product: decodes a triplet, scales the multiplicand and
// places it at weight 4^digit_idx; digits beyond the last real one yield zero.
module booth_pp_gen
    import booth_mac_pkg::*;
#(
    parameter int N_BITS = 16,
    parameter int IDX_W  = 5
) (
    input  logic [N_BITS+1:0]   mcand_ext,
    input  logic [2:0]          triplet,
    input  logic [IDX_W-1:0]    digit_idx,
    output logic [2*N_BITS+3:0] pp
);

    localparam int PW = 2 * N_BITS + 4;
    localparam int EW = N_BITS + 2;
    localparam int G  = N_BITS / 2 + 1;
    localparam logic [IDX_W-1:0] G_IDX = IDX_W'(G);

    logic [PW-1:0]  mag_s;
    logic [PW-1:0]  digit_s;
    logic [IDX_W:0] shamt_s;

    assign mag_s   = {{(PW-EW){mcand_ext[EW-1]}}, mcand_ext};
    assign shamt_s = {digit_idx, 1'b0};

    // Digit decode, scaling and placement of the partial product
    always_comb begin
        digit_s = {PW{1'b0}};
        case (triplet)
            TRIP_ZERO_L, TRIP_ZERO_H: digit_s = {PW{1'b0}};
            TRIP_P1_L, TRIP_P1_H:     digit_s = mag_s;
            TRIP_P2:                  digit_s = {mag_s[PW-2:0], 1'b0};
            TRIP_M2:                  digit_s = -{mag_s[PW-2:0], 1'b0};
            TRIP_M1_L, TRIP_M1_H:     digit_s = -mag_s;
            default:                  digit_s = {PW{1'b0}};
        endcase
        if (digit_idx < G_IDX) begin
            pp = digit_s << shamt_s;
        end else begin
            pp = {PW{1'b0}};
        end
    end

endmodule

// File: rtl/booth_mac_seq.sv
// Iterative radix-4 Booth multiply-accumulate unit retiring GROUPS_PER_CYCLE digits per
// clock, with signed/unsigned operands, a wide accumulator and a sticky overflow flag.
module booth_mac_seq
    import booth_mac_pkg::*;
#(
    parameter int N_BITS           = 16,
    parameter int GROUPS_PER_CYCLE = 1,
    parameter int ACC_BITS         = 2 * N_BITS + 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS-1:0]     multiplicand,
    input  logic [N_BITS-1:0]     multiplier,
    input  logic                  is_signed,
    input  logic                  acc_en,
    input  logic                  acc_clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_BITS-1:0]   product,
    output logic [ACC_BITS-1:0]   acc_out,
    output logic                  acc_ovf,
    output logic                  busy
);

    localparam int C     = calc_cycles(N_BITS, GROUPS_PER_CYCLE);
    localparam int PW    = 2 * N_BITS + 4;
    localparam int EW    = N_BITS + 2;
    localparam int PB    = 2 * N_BITS;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
    localparam int IDX_W = $clog2(C * GROUPS_PER_CYCLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C - 1);

    state_e              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [EW-1:0]       mcand_r;
    logic [EW:0]         mplier_r;      // extended multiplier with the implicit 0 below bit 0
    logic                signed_r;
    logic                acc_en_r;
    logic [PW-1:0]       psum_r;
    logic [PW-1:0]       psum_next_s;
    logic [PB-1:0]       product_r;
    logic [ACC_BITS-1:0] acc_r;
    logic                ovf_r;

    logic                accept_s;
    logic                calc_last_s;
    logic [PB-1:0]       prod_new_s;
    logic [ACC_BITS-1:0] base_s;
    logic [ACC_BITS-1:0] ext_s;
    logic [ACC_BITS:0]   sum_s;
    logic                ovf_s;
    logic [PW-1:0]       pp_arr_s [GROUPS_PER_CYCLE];

    assign in_ready    = (state_r == ST_IDLE);
    assign out_valid   = (state_r == ST_DONE);
    assign busy        = (state_r != ST_IDLE);
    assign product     = product_r;
    assign acc_out     = acc_r;
    assign acc_ovf     = ovf_r;
    assign accept_s    = in_valid & (state_r == ST_IDLE);
    assign calc_last_s = (state_r == ST_CALC) && (cnt_r == CNT_LAST);

    for (genvar j = 0; j < GROUPS_PER_CYCLE; j++) begin : g_pp
        logic [IDX_W-1:0] idx_s;
        logic [2:0]       trip_s;

        assign idx_s  = IDX_W'(cnt_r) * IDX_W'(GROUPS_PER_CYCLE) + IDX_W'(j);
        assign trip_s = 3'(mplier_r >> {idx_s, 1'b0});

        booth_pp_gen #(
            .N_BITS (N_BITS),
            .IDX_W  (IDX_W)
        ) u_pp (
            .mcand_ext (mcand_r),
            .triplet   (trip_s),
            .digit_idx (idx_s),
            .pp        (pp_arr_s[j])
        );
    end

    // Partial sum after this cycle's digits
    always_comb begin
        psum_next_s = psum_r;
        for (int j = 0; j < GROUPS_PER_CYCLE; j++) begin
            psum_next_s = psum_next_s + pp_arr_s[j];
        end
    end

    // Accumulate step; the carry column doubles as the unsigned overflow indicator
    always_comb begin
        prod_new_s = psum_next_s[PB-1:0];
        if (signed_r) begin
            ext_s = {{(ACC_BITS-PB){prod_new_s[PB-1]}}, prod_new_s};
        end else begin
            ext_s = {{(ACC_BITS-PB){1'b0}}, prod_new_s};
        end
        if (acc_en_r) begin
            base_s = acc_r;
        end else begin
            base_s = {ACC_BITS{1'b0}};
        end
        sum_s = {1'b0, base_s} + {1'b0, ext_s};
        if (signed_r) begin
            ovf_s = (base_s[ACC_BITS-1] == ext_s[ACC_BITS-1]) &&
                    (sum_s[ACC_BITS-1] != base_s[ACC_BITS-1]);
        end else begin
            ovf_s = sum_s[ACC_BITS];
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and digit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s || calc_last_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_CALC) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Operand capture with sign/zero extension, and the running partial sum
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {EW{1'b0}};
            mplier_r <= {(EW+1){1'b0}};
            signed_r <= 1'b0;
            acc_en_r <= 1'b0;
            psum_r   <= {PW{1'b0}};
        end else if (accept_s) begin
            mcand_r  <= is_signed ? {{2{multiplicand[N_BITS-1]}}, multiplicand}
                                  : {2'b00, multiplicand};
            mplier_r <= is_signed ? {{2{multiplier[N_BITS-1]}}, multiplier, 1'b0}
                                  : {2'b00, multiplier, 1'b0};
            signed_r <= is_signed;
            acc_en_r <= acc_en;
            psum_r   <= {PW{1'b0}};
        end else if (state_r == ST_CALC) begin
            psum_r <= psum_next_s;
        end
    end

    // Result, accumulator and sticky overflow; a clear with an accept lands before the op
    always_ff @(posedge clk) begin
        if (rst) begin
            product_r <= {PB{1'b0}};
            acc_r     <= {ACC_BITS{1'b0}};
            ovf_r     <= 1'b0;
        end else if ((state_r == ST_IDLE) && acc_clear) begin
            acc_r <= {ACC_BITS{1'b0}};
            ovf_r <= 1'b0;
        end else if (calc_last_s) begin
            product_r <= prod_new_s;
            acc_r     <= sum_s[ACC_BITS-1:0];
            ovf_r     <= ovf_r | ovf_s;
        end
    end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Scoreboard bench for booth_mac_seq: a GPC=1 / 40-bit instance and a GPC=3 / 33-bit instance.
module tb_booth_mac_seq;

    typedef struct {
        logic [31:0] prod;
        logic [39:0] acc;
        logic        ovf;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        rst0, in_valid0, in_ready0, signed0, acc_en0, acc_clear0;
    logic        out_valid0, out_ready0, acc_ovf0, busy0;
    logic [15:0] mcand0, mplier0;
    logic [31:0] product0;
    logic [39:0] acc_out0;

    logic        rst1, in_valid1, in_ready1, signed1, acc_en1, acc_clear1;
    logic        out_valid1, out_ready1, acc_ovf1, busy1;
    logic [15:0] mcand1, mplier1;
    logic [31:0] product1;
    logic [32:0] acc_out1;

    booth_mac_seq #(.N_BITS(16), .GROUPS_PER_CYCLE(1), .ACC_BITS(40)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(in_valid0), .in_ready(in_ready0),
        .multiplicand(mcand0), .multiplier(mplier0), .is_signed(signed0),
        .acc_en(acc_en0), .acc_clear(acc_clear0), .out_valid(out_valid0),
        .out_ready(out_ready0), .product(product0), .acc_out(acc_out0),
        .acc_ovf(acc_ovf0), .busy(busy0)
    );

    booth_mac_seq #(.N_BITS(16), .GROUPS_PER_CYCLE(3), .ACC_BITS(33)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .multiplicand(mcand1), .multiplier(mplier1), .is_signed(signed1),
        .acc_en(acc_en1), .acc_clear(acc_clear1), .out_valid(out_valid1),
        .out_ready(out_ready1), .product(product1), .acc_out(acc_out1),
        .acc_ovf(acc_ovf1), .busy(busy1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst0 && out_valid0 && out_ready0) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected output", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                check({e.nm, " product"}, {32'd0, product0}, {32'd0, e.prod});
                check({e.nm, " acc_out"}, {24'd0, acc_out0}, {24'd0, e.acc});
                check({e.nm, " acc_ovf"}, {63'd0, acc_ovf0}, {63'd0, e.ovf});
            end
        end
        if (!rst1 && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected output", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check({e.nm, " product"}, {32'd0, product1}, {32'd0, e.prod});
                check({e.nm, " acc_out"}, {31'd0, acc_out1}, {24'd0, e.acc});
                check({e.nm, " acc_ovf"}, {63'd0, acc_ovf1}, {63'd0, e.ovf});
            end
        end
    end

    function automatic logic sel_valid(input int sel);
        return (sel == 0) ? out_valid0 : out_valid1;
    endfunction

    // Issue one op (called at posedge+1), push its expectation, wait for and retire the result
    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic en, input logic clr,
                         input logic [31:0] ep, input logic [39:0] ea, input logic eo,
                         input int hold, input string nm);
        int lat;
        int exp_lat;
        exp_lat = (sel == 0) ? 10 : 4;
        if (sel == 0) begin
            check({nm, " in_ready before"}, {63'd0, in_ready0}, 64'd1);
            mcand0 = a; mplier0 = b; signed0 = s; acc_en0 = en; acc_clear0 = clr;
            in_valid0 = 1'b1; out_ready0 = (hold == 0);
            q0.push_back('{ep, ea, eo, nm});
        end else begin
            check({nm, " in_ready before"}, {63'd0, in_ready1}, 64'd1);
            mcand1 = a; mplier1 = b; signed1 = s; acc_en1 = en; acc_clear1 = clr;
            in_valid1 = 1'b1; out_ready1 = (hold == 0);
            q1.push_back('{ep, ea, eo, nm});
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0; acc_clear0 = 1'b0; in_valid1 = 1'b0; acc_clear1 = 1'b0;
        lat = 1;
        while (!sel_valid(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            check({nm, " hold valid"}, {63'd0, out_valid0}, 64'd1);
            check({nm, " hold in_ready"}, {63'd0, in_ready0}, 64'd0);
            check({nm, " hold product"}, {32'd0, product0}, {32'd0, ep});
            check({nm, " hold acc"}, {24'd0, acc_out0}, {24'd0, ea});
            @(posedge clk); #1;
        end
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) check({nm, " in_ready after"}, {63'd0, in_ready0}, 64'd1);
        else          check({nm, " in_ready after"}, {63'd0, in_ready1}, 64'd1);
    endtask

    task automatic check_reset0(input string nm);
        check({nm, " in_ready"},  {63'd0, in_ready0},  64'd1);
        check({nm, " out_valid"}, {63'd0, out_valid0}, 64'd0);
        check({nm, " busy"},      {63'd0, busy0},      64'd0);
        check({nm, " product"},   {32'd0, product0},   64'd0);
        check({nm, " acc_out"},   {24'd0, acc_out0},   64'd0);
        check({nm, " acc_ovf"},   {63'd0, acc_ovf0},   64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; in_valid0 = 1'b0; signed0 = 1'b0; acc_en0 = 1'b0; acc_clear0 = 1'b0;
        out_ready0 = 1'b1; mcand0 = 16'd0; mplier0 = 16'd0;
        rst1 = 1'b1; in_valid1 = 1'b0; signed1 = 1'b0; acc_en1 = 1'b0; acc_clear1 = 1'b0;
        out_ready1 = 1'b1; mcand1 = 16'd0; mplier1 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset0("reset");
        rst0 = 1'b0; rst1 = 1'b0;
        @(posedge clk); #1;

        do_op(0, 16'hFFFD, 16'h0007, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFEB, 40'hFF_FFFF_FFEB, 1'b0, 0, "sgn -3x7");
        do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE_0001, 40'h00_FFFE_0001, 1'b0, 0, "uns ffff2");
        do_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 40'h00_0000_0001, 1'b0, 0, "sgn ffff2");
        do_op(0, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 40'h00_4000_0000, 1'b0, 0, "sgn 8000sq");
        do_op(0, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b1, 32'd1000000, 40'd1000000, 1'b0, 0, "acc1");
        do_op(0, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b0, 32'd1000000, 40'd2000000, 1'b0, 0, "acc2");
        do_op(0, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b0, 32'd1000000, 40'd3000000, 1'b0, 5, "acc3 bp");

        acc_clear0 = 1'b1;
        @(posedge clk); #1;
        acc_clear0 = 1'b0;
        check("clear acc_out", {24'd0, acc_out0}, 64'd0);
        check("clear acc_ovf", {63'd0, acc_ovf0}, 64'd0);

        do_op(0, 16'd1000, 16'd1000, 1'b1, 1'b1, 1'b0, 32'd1000000, 40'd1000000, 1'b0, 0, "pre-rst");

        // start an op, then abort it with reset while the counter holds 4
        mcand0 = 16'd1000; mplier0 = 16'd1000; signed0 = 1'b1; acc_en0 = 1'b1; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        check("mid busy", {63'd0, busy0}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        check_reset0("mid-rst");

        do_op(0, 16'd5, 16'd6, 1'b1, 1'b0, 1'b0, 32'd30, 40'd30, 1'b0, 0, "5x6");

        do_op(1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 40'h00_4000_0000, 1'b0, 0, "g3 8000sq");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1, 32'h3FFF_0001, 40'h00_3FFF_0001, 1'b0, 0, "ovf1");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h3FFF_0001, 40'h00_7FFE_0002, 1'b0, 0, "ovf2");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h3FFF_0001, 40'h00_BFFD_0003, 1'b0, 0, "ovf3");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h3FFF_0001, 40'h00_FFFC_0004, 1'b0, 0, "ovf4");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h3FFF_0001, 40'h01_3FFB_0005, 1'b1, 0, "ovf5");
        do_op(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 32'h3FFF_0001, 40'h01_7FFA_0006, 1'b1, 0, "ovf6");

        acc_clear1 = 1'b1;
        @(posedge clk); #1;
        acc_clear1 = 1'b0;
        check("g3 clear acc_out", {31'd0, acc_out1}, 64'd0);
        check("g3 clear acc_ovf", {63'd0, acc_ovf1}, 64'd0);

        check("q0 drained", 64'(q0.size()), 64'd0);
        check("q1 drained", 64'(q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
